// File: rtl/rv32i_lsu.sv
// rv32i_lsu -- load/store unit between a RISC-V pipeline and a simple
// request/ack memory bus.
//
// Accepts one access at a time (req_valid/req_ready). The access is decoded,
// then issued as one or two lane-aligned bus beats. A second beat is used
// only when the access crosses a DATA_W boundary and MISALIGN_EN=1. The
// result is returned as a one-cycle rsp_valid pulse.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           access handshake
//   req_we, req_funct3            store flag, RISC-V size/sign encoding
//   req_addr, req_wdata           byte address, right-justified store data
//   rsp_valid, rsp_rdata, rsp_err response pulse, extended load data, error
//   mem_req/mem_ack               bus beat handshake (request held until ack)
//   mem_we, mem_addr              beat direction, beat-aligned address
//   mem_wdata, mem_wmask          lane-aligned store data and byte mask
//   mem_rdata                     read data, valid with mem_ack
module rv32i_lsu #(
  parameter int DATA_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int LW = 2 * NB;
  localparam int DW2 = 2 * DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP, S_ERR} state_t;

  state_t            r_state;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [OW-1:0]     r_off;
  logic              r_cross;
  logic [31:0]       r_base;
  logic [DATA_W-1:0] r_wd1;
  logic [NB-1:0]     r_mk1;
  logic [DATA_W-1:0] r_res;

  // ---------------- request decode ----------------
  logic [OW-1:0]     w_off;
  logic [2:0]        w_f3;
  logic              w_illegal;
  logic [3:0]        w_szm1;
  logic              w_mis;
  logic [4:0]        w_end;
  logic              w_cross;
  logic [31:0]       w_base;
  logic [LW-1:0]     w_lanes;
  logic [DW2-1:0]    w_wd2;

  always_comb begin
    w_off     = req_addr[OW-1:0];
    // Unsigned store encodings behave as their signed counterparts.
    w_f3      = (req_we && req_funct3[2]) ? {1'b0, req_funct3[1:0]} : req_funct3;
    w_illegal = (req_funct3 == 3'b111) ||
                ((DATA_W == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110))) ||
                (req_we && (req_funct3 == 3'b110));
    w_szm1    = (4'd1 << w_f3[1:0]) - 4'd1;
    w_mis     = ((4'(w_off) & w_szm1) != 4'd0);
    w_end     = 5'(w_off) + 5'(w_szm1) + 5'd1;
    w_cross   = (w_end > 5'(NB));
    w_base    = {req_addr[31:OW], {OW{1'b0}}};
    // Two-beat-wide lane mask and data: low half is beat 0, high half beat 1.
    w_lanes   = ((LW'(1) << (int'(w_szm1) + 1)) - LW'(1)) << w_off;
    w_wd2     = DW2'(req_wdata) << {w_off, 3'b000};
  end

  // ---------------- read-data assembly ----------------
  logic [OW:0]       w_sh1;
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_raw;
  logic              w_sign;
  logic [DATA_W-1:0] w_ext;

  always_comb begin
    w_sh1 = (OW+1)'(NB) - (OW+1)'(r_off);
    w_lo  = mem_rdata >> {r_off, 3'b000};
    // Beat-1 lanes land directly above the bytes captured from beat 0.
    w_hi  = r_res | (mem_rdata << {w_sh1, 3'b000});
    w_raw = (r_state == S_BEAT1) ? w_hi : w_lo;
    case (r_f3[1:0])
      2'd0:    w_sign = w_raw[7];
      2'd1:    w_sign = w_raw[15];
      2'd2:    w_sign = w_raw[31];
      default: w_sign = w_raw[DATA_W-1];
    endcase
    if (r_f3[2]) w_sign = 1'b0;
    w_ext = '0;
    for (int i = 0; i < NB; i++)
      w_ext[8*i +: 8] = (i < (1 << r_f3[1:0])) ? w_raw[8*i +: 8] : {8{w_sign}};
  end

  // ---------------- FSM with registered outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_off     <= '0;
      r_cross   <= 1'b0;
      r_base    <= '0;
      r_wd1     <= '0;
      r_mk1     <= '0;
      r_res     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_we      <= req_we;
            r_f3      <= w_f3;
            r_off     <= w_off;
            r_cross   <= w_cross;
            r_base    <= w_base;
            r_wd1     <= w_wd2[DW2-1:DATA_W];
            r_mk1     <= req_we ? w_lanes[LW-1:NB] : '0;
            if (w_illegal || (w_mis && (MISALIGN_EN == 0))) begin
              r_state   <= S_ERR;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              r_state   <= S_BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= w_base;
              mem_wdata <= w_wd2[DATA_W-1:0];
              mem_wmask <= req_we ? w_lanes[NB-1:0] : '0;
            end
          end
        end
        S_BEAT0, S_BEAT1: begin
          if (mem_ack) begin
            if ((r_state == S_BEAT0) && r_cross) begin
              r_state   <= S_BEAT1;
              r_res     <= w_lo;
              mem_addr  <= r_base + 32'(NB);  // wraps modulo 2^32
              mem_wdata <= r_wd1;
              mem_wmask <= r_mk1;
            end else begin
              r_state   <= S_RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              mem_wmask <= '0;
              rsp_valid <= 1'b1;
              rsp_rdata <= r_we ? '0 : w_ext;
            end
          end
        end
        S_RESP, S_ERR: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32i_lsu.sv
// Scoreboard bench for rv32i_lsu. Three instances share stimulus:
//   0: DATA_W=32 MISALIGN_EN=1, 1: DATA_W=32 MISALIGN_EN=0, 2: DATA_W=64.
// Only one instance is active at a time (sel). Expected bus beats and
// responses are queued by the driver; a bus responder and a response
// monitor pop and compare independently.
module tb_rv32i_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  rsp_valid, rsp_err, mem_req, mem_we;
  logic [2:0]  mem_ack = '0;
  logic [63:0] mem_rdata = '0;
  logic [63:0] rsp_rdata [3];
  logic [31:0] mem_addr  [3];
  logic [63:0] mem_wdata [3];
  logic [7:0]  mem_wmask [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = (g == 2) ? 64 : 32;
    localparam int ME = (g == 1) ? 0 : 1;
    logic [DW-1:0]   rd, wd;
    logic [DW/8-1:0] wm;
    rv32i_lsu #(.DATA_W(DW), .MISALIGN_EN(ME)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[DW-1:0]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rd), .rsp_err(rsp_err[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(wd), .mem_wmask(wm), .mem_ack(mem_ack[g]), .mem_rdata(mem_rdata[DW-1:0]));
    assign rsp_rdata[g] = 64'(rd);
    assign mem_wdata[g] = 64'(wd);
    assign mem_wmask[g] = 8'(wm);
  end

  typedef struct { int id; logic [63:0] rd; logic err; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [7:0] mask; logic [63:0] wd; logic [63:0] rd; int waits; } beat_t;

  rsp_t  rsp_q[$];
  beat_t beat_q[$];
  int    n_vec = 0, n_err = 0;
  int    cyc = 0;
  int    sel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] bm(input logic [7:0] m);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // ---------------- bus responder ----------------
  logic        serving = 1'b0;
  beat_t       cur;
  int          wcnt = 0;
  logic [31:0] h_addr;
  logic [63:0] h_wd;
  logic [7:0]  h_m;

  always @(negedge clk) begin
    mem_ack = '0;
    if (rst) serving = 1'b0;
    else if (mem_req[sel]) begin
      if (!serving) begin
        if (beat_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL beat_unexpected: dut %0d addr %h, no beat pending", sel, mem_addr[sel]);
          mem_ack[sel] = 1'b1;
          mem_rdata    = '0;
        end else begin
          cur     = beat_q.pop_front();
          serving = 1'b1;
          wcnt    = cur.waits;
          h_addr  = mem_addr[sel];
          h_wd    = mem_wdata[sel];
          h_m     = mem_wmask[sel];
          chk("beat_addr", h_addr, cur.addr);
          chk("beat_we", mem_we[sel], cur.we);
          chk("beat_mask", h_m, cur.mask);
          chk("beat_wdata", h_wd & bm(cur.mask), cur.wd & bm(cur.mask));
        end
      end else begin
        chk("hold_addr", mem_addr[sel], h_addr);
        chk("hold_wdata", mem_wdata[sel], h_wd);
        chk("hold_mask", mem_wmask[sel], h_m);
      end
      if (serving) begin
        if (wcnt == 0) begin
          mem_ack[sel] = 1'b1;
          mem_rdata    = cur.rd;
          serving      = 1'b0;
        end else wcnt--;
      end
    end
  end

  // ---------------- response monitor ----------------
  rsp_t e;
  always @(negedge clk) begin
    if (!rst && (rsp_valid != 3'b000)) begin
      if (rsp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rsp_unexpected: rsp_valid=%b with nothing pending", rsp_valid);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_id", 64'(rsp_valid), 64'(1) << e.id);
        chk("rsp_rdata", rsp_rdata[e.id], e.rd);
        chk("rsp_err", rsp_err[e.id], e.err);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic beat(input logic [31:0] a, input logic we, input logic [7:0] m,
                      input logic [63:0] wd, input logic [63:0] rd, input int waits);
    beat_t b;
    b.addr = a; b.we = we; b.mask = m; b.wd = wd; b.rd = rd; b.waits = waits;
    beat_q.push_back(b);
  endtask

  // lat < 0 means the access is expected to produce no response.
  task automatic issue(input int id, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err, input int lat);
    int   k = 0;
    rsp_t r;
    sel = id;
    while (!req_ready[id] && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin
      n_vec++; n_err++;
      $display("FAIL req_ready_timeout: dut %0d never ready", id);
    end
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = '0; req_valid[id] = 1'b1;
    if (lat >= 0) begin
      r.id = id; r.rd = exp_rd; r.err = exp_err; r.cyc = cyc + lat;
      rsp_q.push_back(r);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((rsp_q.size() != 0 || beat_q.size() != 0 || serving) && k < 100) begin
      @(negedge clk); k++;
    end
    if (k >= 100) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: rsp_q=%0d beat_q=%0d still pending", rsp_q.size(), beat_q.size());
      rsp_q.delete(); beat_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int k;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'h7);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_mem_we", 64'(mem_we), 64'h0);
    for (int g = 0; g < 3; g++) begin
      chk("rst_rsp_rdata", rsp_rdata[g], 64'h0);
      chk("rst_mem_addr", mem_addr[g], 64'h0);
      chk("rst_mem_wdata", mem_wdata[g], 64'h0);
      chk("rst_mem_wmask", mem_wmask[g], 64'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // DATA_W=32, MISALIGN_EN=1
    beat(32'h100, 0, 8'h0, 0, 64'h80FF_FFFF, 0);                       // lb, sign
    issue(0, 0, 3'b000, 32'h103, 0, 64'hFFFF_FF80, 0, 2); wait_idle();
    beat(32'h100, 1, 8'hC, 64'hCCDD_0000, 0, 0);                       // sw crossing
    beat(32'h104, 1, 8'h3, 64'h0000_AABB, 0, 0);
    issue(0, 1, 3'b010, 32'h102, 64'hAABB_CCDD, 0, 0, 3); wait_idle();
    beat(32'h100, 0, 8'h0, 0, 64'h1234_5678, 1);                       // lhu crossing, waits
    beat(32'h104, 0, 8'h0, 0, 64'hABCD_EF34, 2);
    issue(0, 0, 3'b101, 32'h103, 0, 64'h0000_3412, 0, 6); wait_idle();
    beat(32'h100, 0, 8'h0, 0, 64'h8001_0000, 0);                       // lh, sign
    issue(0, 0, 3'b001, 32'h102, 0, 64'hFFFF_8001, 0, 2); wait_idle();
    beat(32'h100, 0, 8'h0, 0, 64'h0000_9A00, 0);                       // lbu
    issue(0, 0, 3'b100, 32'h101, 0, 64'h0000_009A, 0, 2); wait_idle();
    beat(32'h200, 0, 8'h0, 0, 64'hDEAD_BEEF, 0);                       // lw
    issue(0, 0, 3'b010, 32'h200, 0, 64'hDEAD_BEEF, 0, 2); wait_idle();
    beat(32'h004, 1, 8'h8, 64'h4500_0000, 0, 0);                       // sb lane 3
    issue(0, 1, 3'b000, 32'h007, 64'hFFFF_FF45, 0, 0, 2); wait_idle();
    beat(32'h000, 1, 8'h2, 64'h0000_7700, 0, 0);                       // 100 store acts as sb
    issue(0, 1, 3'b100, 32'h001, 64'h0000_0077, 0, 0, 2); wait_idle();
    beat(32'h100, 0, 8'h0, 0, 64'h00F0_0F00, 0);                       // misaligned, no cross
    issue(0, 0, 3'b001, 32'h101, 0, 64'hFFFF_F00F, 0, 2); wait_idle();
    beat(32'hFFFF_FFFC, 0, 8'h0, 0, 64'hBBAA_0000, 0);                 // wrap to 0
    beat(32'h0000_0000, 0, 8'h0, 0, 64'h0000_DDCC, 0);
    issue(0, 0, 3'b010, 32'hFFFF_FFFE, 0, 64'hDDCC_BBAA, 0, 3); wait_idle();
    issue(0, 0, 3'b111, 32'h100, 0, 0, 1, 1); wait_idle();             // illegal encodings
    issue(0, 0, 3'b011, 32'h100, 0, 0, 1, 1); wait_idle();
    issue(0, 0, 3'b110, 32'h100, 0, 0, 1, 1); wait_idle();
    issue(0, 1, 3'b110, 32'h100, 0, 0, 1, 1); wait_idle();

    // DATA_W=32, MISALIGN_EN=0
    issue(1, 0, 3'b010, 32'h101, 0, 0, 1, 1); wait_idle();
    issue(1, 0, 3'b010, 32'h102, 0, 0, 1, 1); wait_idle();
    issue(1, 0, 3'b011, 32'h100, 0, 0, 1, 1); wait_idle();
    beat(32'h100, 0, 8'h0, 0, 64'h7FFF_0000, 0);
    issue(1, 0, 3'b001, 32'h102, 0, 64'h0000_7FFF, 0, 2); wait_idle();

    // DATA_W=64
    beat(32'h0, 1, 8'hFF, 64'h1122_3344_5566_7788, 0, 3);
    issue(2, 1, 3'b011, 32'h0, 64'h1122_3344_5566_7788, 0, 0, 5); wait_idle();
    beat(32'h8, 0, 8'h00, 0, 64'h8000_0000_0000_0001, 3);
    issue(2, 0, 3'b011, 32'h8, 0, 64'h8000_0000_0000_0001, 0, 5); wait_idle();
    beat(32'h8, 0, 8'h00, 0, 64'h89AB_CDEF_0000_0000, 0);
    issue(2, 0, 3'b110, 32'hC, 0, 64'h0000_0000_89AB_CDEF, 0, 2); wait_idle();
    beat(32'h8, 0, 8'h00, 0, 64'h89AB_CDEF_0000_0000, 0);
    issue(2, 0, 3'b010, 32'hC, 0, 64'hFFFF_FFFF_89AB_CDEF, 0, 2); wait_idle();
    beat(32'h08, 0, 8'h00, 0, 64'h2211_0000_0000_0000, 0);
    beat(32'h10, 0, 8'h00, 0, 64'h0000_0000_0000_4433, 0);
    issue(2, 0, 3'b010, 32'hE, 0, 64'h0000_0000_4433_2211, 0, 3); wait_idle();
    beat(32'h0, 1, 8'hF0, 64'h0403_0201_0000_0000, 0, 0);
    beat(32'h8, 1, 8'h0F, 64'h0000_0000_0807_0605, 0, 0);
    issue(2, 1, 3'b011, 32'h4, 64'h0807_0605_0403_0201, 0, 0, 3); wait_idle();
    issue(2, 0, 3'b111, 32'h0, 0, 0, 1, 1); wait_idle();

    // Reset during beat 1 abandons the access.
    beat(32'h100, 0, 8'h0, 0, 64'h1111_1111, 0);
    beat(32'h104, 0, 8'h0, 0, 64'h2222_2222, 10);
    issue(0, 0, 3'b010, 32'h102, 0, 0, 0, -1);
    k = 0;
    while (!(mem_req[0] && mem_addr[0] == 32'h104) && k < 20) begin @(negedge clk); k++; end
    chk("beat1_reached", mem_addr[0], 32'h104);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_mem_req", 64'(mem_req[0]), 64'h0);
    chk("rst_async_ready", 64'(req_ready[0]), 64'h1);
    beat_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(req_ready[0]), 64'h1);
    repeat (5) @(negedge clk);
    chk("no_rsp_after_rst", 64'(rsp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 Parameter DATA_W, default 32, meaning memory bus data width in bits; legal values are 32 and 64; byte lanes NB = DATA_W/8.
REQ-002 Parameter MISALIGN_EN, default 1, meaning 1 splits beat-crossing accesses into two bus beats and 0 reports every misaligned access as an error.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  pipeline presents an access.
REQ-006 req_ready  output  1  block can accept an access.
REQ-007 req_we  input  1  1 means store and 0 means load.
REQ-008 req_funct3  input  3  access size and sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  DATA_W  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle response pulse with no backpressure.
REQ-012 rsp_rdata  output  DATA_W  load result, zero- or sign-extended; 0 for stores.
REQ-013 rsp_err  output  1  misaligned access (MISALIGN_EN=0) or illegal funct3.
REQ-014 mem_req  output  1  bus request, held until mem_ack.
REQ-015 mem_we  output  1  bus write enable.
REQ-016 mem_addr  output  32  beat address with the low log2(NB) bits equal to 0.
REQ-017 mem_wdata  output  DATA_W  lane-aligned store data.
REQ-018 mem_wmask  output  NB  byte-lane write mask; all 0 for reads.
REQ-019 mem_ack  input  1  beat complete; mem_rdata is valid in the same cycle.
REQ-020 mem_rdata  input  DATA_W  read data.

Function
REQ-021 Size is S = 1<<funct3[1:0] bytes and offset is off = req_addr mod NB; the access is misaligned when off mod S != 0 and crosses a beat when off+S > NB.
REQ-022 funct3 is illegal if it is 111, or if it is 011 or 110 while DATA_W=32; 110 (wu) is also illegal with req_we=1, and 100/101 with req_we=1 are treated as 000/001.
REQ-023 FSM states are IDLE, BEAT0, BEAT1, RESP, ERR; req_ready=1 only in IDLE, and handshake = req_valid & req_ready.
REQ-024 On a handshake, all request fields are captured, and the next state is ERR if the request is illegal or (misaligned and MISALIGN_EN=0), otherwise BEAT0.
REQ-025 ERR lasts one cycle, drives rsp_valid=1, rsp_err=1 and rsp_rdata=0, then returns to IDLE; no bus traffic occurs.
REQ-026 In BEAT0, mem_req=1 with mem_addr = addr aligned down to NB, lanes off..min(off+S,NB)-1, and wdata = req_wdata shifted left by 8*off (truncated to DATA_W).
REQ-027 In BEAT1 (crossing accesses only), mem_addr = BEAT0 address + NB, lanes 0..off+S-NB-1, and wdata = req_wdata shifted right by 8*(NB-off).
REQ-028 The mem_* outputs stay stable while mem_req=1 and mem_ack=0; a BEAT0 ack moves to BEAT1 if the access crosses a beat, else to RESP.
REQ-029 On a BEAT0 ack, the lanes off..NB-1 of mem_rdata are captured into the low result bytes; on a BEAT1 ack, lanes 0.. are captured into the upper result bytes, then the FSM moves to RESP.
REQ-030 RESP lasts one cycle with rsp_valid=1 and rsp_err=0; rsp_rdata is the S-byte result, sign-extended when funct3[2]=0 and zero-extended when funct3[2]=1; the FSM then returns to IDLE.
REQ-031 Latency: handshake at cycle T puts mem_req=1 at T+1; the final ack at cycle A gives rsp_valid at A+1; a zero-wait single beat responds at T+2.
REQ-032 mem_ack outside BEAT0/BEAT1 is ignored, and at most one access is outstanding.
REQ-033 An access at the top of the address space wraps BEAT1 to address 0 (modulo 2^32).

Reset
REQ-034 While rst=1, asynchronously: state=IDLE, req_ready=1, and rsp_valid, rsp_err, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata and mem_wmask are all 0.
REQ-035 Reset during BEAT0, BEAT1 or RESP abandons the access: mem_req drops immediately and no rsp_valid is issued for it.

Verification
REQ-036 DATA_W=32, lb at addr 0x103 with mem_rdata=0x80FF_FFFF -> one beat to 0x100, rsp_rdata=0xFFFF_FF80, rsp_valid at T+2.
REQ-037 DATA_W=32, MISALIGN_EN=1, sw of 0xAABBCCDD at 0x102 -> beat0 at 0x100 with mask 1100 and wdata 0xCCDD_xxxx, then beat1 at 0x104 with mask 0011 and wdata 0xxxxx_AABB.
REQ-038 DATA_W=32, MISALIGN_EN=1, lhu at 0x103 with beat0 rdata 0x12xx_xxxx and beat1 rdata 0xxxxx_xx34 -> rsp_rdata=0x0000_3412.
REQ-039 MISALIGN_EN=0, lw at 0x101 -> rsp_valid and rsp_err at T+1, mem_req never asserted; DATA_W=32 with funct3=011 -> rsp_err.
REQ-040 DATA_W=64, ld at 0x0 with 3 wait cycles -> mem_req held stable for 4 cycles, mask 0xFF, rsp_valid one cycle after ack.
REQ-041 rst asserted in BEAT1 -> mem_req=0 in the same cycle, no response is issued, and req_ready=1 after release.
